sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO for same-domain buffering between producer and consumer blocks. It is the synchronous successor to the team's dual-clock FIFO. It keeps the same write/read/flag port vocabulary and adds:
- an occupancy count output;
- sticky error flags with a clear input;
- a selectable first-word-fall-through (FWFT) read mode.

## Interface
Parameters:
- DSIZE, 8, data width in bits
- ASIZE, 4, address width; DEPTH = 2**ASIZE entries
- FULL_THRESHOLD, 1, almost_full asserts when free entries <= FULL_THRESHOLD
- EMPTY_THRESHOLD, 1, almost_empty asserts when used entries <= EMPTY_THRESHOLD
- FWFT, 0, 0 = registered read (standard), 1 = first-word-fall-through

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- winc  in  1  write request
- wdata  in  DSIZE  write data
- wfull  out  1  count == DEPTH
- almost_full  out  1  count >= DEPTH - FULL_THRESHOLD
- overflow_error  out  1  sticky; set by winc while wfull
- rinc  in  1  read request
- rdata  out  DSIZE  read data
- rempty  out  1  count == 0
- almost_empty  out  1  count <= EMPTY_THRESHOLD
- underflow_error  out  1  sticky; set by rinc while rempty
- err_clr  in  1  clears both sticky error flags
- count  out  ASIZE+1  current occupancy, 0..DEPTH

## Operation
- Write is accepted iff winc && !wfull. Data goes to mem[wptr], and wptr increments modulo DEPTH.
- Read is accepted iff rinc && !rempty. rptr increments modulo DEPTH.
- Flags are evaluated from registered state only. On a full FIFO, a simultaneous winc+rinc accepts the read, rejects the write and sets overflow_error. On an empty FIFO, a simultaneous winc+rinc accepts the write, rejects the read and sets underflow_error.
- count update: +1 on write only, -1 on read only, unchanged on both or neither. count never exceeds DEPTH and never drops below 0.
- Sticky errors: the set condition has priority over err_clr in the same cycle. Otherwise err_clr drives the flag to 0 on the next edge.
- FWFT=0: on an accepted read, rdata is loaded with mem[rptr] at that edge. rdata holds its value otherwise, including during a rejected read.
- FWFT=1: rdata is driven by mem[rptr] continuously and is valid whenever rempty==0. An accepted rinc advances to the next word.
- Rejected operations change no pointer, count or memory.
- Reset clears:
  - wptr, rptr and count to 0;
  - rempty=1, almost_empty=1, wfull=0, almost_full=0 (the last only if DEPTH - FULL_THRESHOLD > 0);
  - both error flags to 0;
  - rdata to 0 when FWFT=0.
- Reset does not clear memory contents. Reset during traffic discards all data; requests presented in the reset cycle are ignored.
- Threshold legality: 0 <= FULL_THRESHOLD < DEPTH and 0 <= EMPTY_THRESHOLD < DEPTH. Checked by elaboration-time assertion.

## Timing
- All outputs are registered except rdata in FWFT=1 mode, which is combinational from registered pointer and memory.
- Write-to-visible latency: rempty and count reflect a write on the edge that accepts it, so they change 1 cycle after winc is sampled.
  - FWFT=1: first word is on rdata in the same cycle rempty falls.
  - FWFT=0: data appears on rdata 1 cycle after the accepted rinc.
- Flags are derived from the next-state count and registered alongside count, so wfull, almost_* and count are always mutually consistent.
- Throughput: 1 write and 1 read per cycle sustained, including across pointer wrap from DEPTH-1 to 0.

## Structure
- Package sync_fifo_pkg holds:
  - localparam-style helper functions (depth from ASIZE, threshold checks);
  - the count-width typedef, parameterised via ASIZE in the top.
- One sub-module: sync_fifo_mem, a simple dual-port array with a synchronous write port and an asynchronous read port. Parameters are DSIZE and ASIZE. It is reused for both FWFT modes; FWFT=0 adds an output register in the top.
- The top holds pointers, count, flag registers and error logic.

## Test plan
Defaults unless noted: DSIZE=8, ASIZE=4 (DEPTH 16), thresholds 1.
- Reset: hold rst 2 cycles with winc=rinc=1 -> count=0, rempty=1, almost_empty=1, wfull=0, almost_full=0, both errors 0, rdata=0x00.
- Fill: write 0x01..0x10 back-to-back -> almost_empty drops at count=2, almost_full rises at count=15, wfull at count=16. 17th winc -> overflow_error=1, count stays 16. err_clr one cycle -> overflow_error=0.
- Drain (FWFT=0): 16 reads -> rdata 0x01..0x10 in order, each 1 cycle after its rinc. 17th rinc -> underflow_error=1, rdata holds 0x10, count=0.
- Wrap and concurrency:
  - Preload 8 words, then 40 cycles of simultaneous winc+rinc -> count stays 8, data in order across multiple pointer wraps.
  - winc+rinc on full -> read accepted, overflow set, count=15.
- FWFT=1: write 0xA5 at cycle 0 -> rempty=0 and rdata=0xA5 after that edge with no rinc. Write 0x5A, then rinc -> rdata=0x5A next cycle.
- Reset mid-operation: with count=9, assert rst 1 cycle -> count=0, rempty=1, errors 0. Next write 0x33 then read -> 0x33, with no stale data.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO: depth derivation and threshold legality.
package sync_fifo_pkg;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    function automatic bit threshold_legal(input int thr, input int depth);
        return (thr >= 0) && (thr < depth);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, sticky over/underflow flags and
// selectable registered or first-word-fall-through read data.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE           = 8,
    parameter int ASIZE           = 4,
    parameter int FULL_THRESHOLD  = 1,
    parameter int EMPTY_THRESHOLD = 1,
    parameter int FWFT            = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             almost_full,
    output logic             overflow_error,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             almost_empty,
    output logic             underflow_error,
    input  logic             err_clr,
    output logic [ASIZE:0]   count
);

    localparam int DEPTH = fifo_depth(ASIZE);

    typedef logic [ASIZE:0]   count_t;
    typedef logic [ASIZE-1:0] ptr_t;

    localparam count_t FULL_LVL    = count_t'(DEPTH);
    localparam count_t AFULL_LVL   = count_t'(DEPTH - FULL_THRESHOLD);
    localparam count_t AEMPTY_LVL  = count_t'(EMPTY_THRESHOLD);

    if (!threshold_legal(FULL_THRESHOLD, DEPTH) || !threshold_legal(EMPTY_THRESHOLD, DEPTH)) begin : g_bad_threshold
        $error("sync_fifo: thresholds must lie in [0, DEPTH)");
    end

    ptr_t   wptr_q, wptr_d, rptr_q, rptr_d;
    count_t count_q, count_d;
    logic   wfull_q, wfull_d, almost_full_q, almost_full_d;
    logic   rempty_q, rempty_d, almost_empty_q, almost_empty_d;
    logic   overflow_q, overflow_d, underflow_q, underflow_d;
    logic   wr_ok, rd_ok;
    logic [DSIZE-1:0] mem_rdata;

    always_comb begin
        wr_ok  = winc && !wfull_q;
        rd_ok  = rinc && !rempty_q;
        wptr_d = wr_ok ? wptr_q + ptr_t'(1) : wptr_q;
        rptr_d = rd_ok ? rptr_q + ptr_t'(1) : rptr_q;
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + count_t'(1);
            2'b01:   count_d = count_q - count_t'(1);
            default: count_d = count_q;
        endcase
        // Flags come from the next count so they update together with it.
        wfull_d        = (count_d == FULL_LVL);
        almost_full_d  = (count_d >= AFULL_LVL);
        rempty_d       = (count_d == '0);
        almost_empty_d = (count_d <= AEMPTY_LVL);
        overflow_d     = (winc && wfull_q)  ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
        underflow_d    = (rinc && rempty_q) ? 1'b1 : (err_clr ? 1'b0 : underflow_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            wfull_q        <= 1'b0;
            almost_full_q  <= 1'b0;
            rempty_q       <= 1'b1;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            wfull_q        <= wfull_d;
            almost_full_q  <= almost_full_d;
            rempty_q       <= rempty_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .wen   (wr_ok && !rst),
        .waddr (wptr_q),
        .wdata (wdata),
        .raddr (rptr_q),
        .rdata (mem_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign rdata = mem_rdata;
    end else begin : g_reg_read
        logic [DSIZE-1:0] rdata_q, rdata_d;

        always_comb begin
            rdata_d = rd_ok ? mem_rdata : rdata_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata = rdata_q;
    end

    assign wfull           = wfull_q;
    assign almost_full     = almost_full_q;
    assign rempty          = rempty_q;
    assign almost_empty    = almost_empty_q;
    assign overflow_error  = overflow_q;
    assign underflow_error = underflow_q;
    assign count           = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: vector table for reset/fill/drain, hand sequences for wrap, full concurrency, reset and FWFT.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc, rinc, err_clr;
    logic [7:0] wdata, rdata;
    logic       wfull, almost_full, overflow_error, rempty, almost_empty, underflow_error;
    logic [4:0] count;

    logic       f_winc, f_rinc, f_err_clr;
    logic [7:0] f_wdata, f_rdata;
    logic       f_wfull, f_almost_full, f_overflow, f_rempty, f_almost_empty, f_underflow;
    logic [4:0] f_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DSIZE(8), .ASIZE(4), .FULL_THRESHOLD(1), .EMPTY_THRESHOLD(1), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull),
        .almost_full(almost_full), .overflow_error(overflow_error), .rinc(rinc),
        .rdata(rdata), .rempty(rempty), .almost_empty(almost_empty),
        .underflow_error(underflow_error), .err_clr(err_clr), .count(count)
    );

    sync_fifo #(.DSIZE(8), .ASIZE(4), .FULL_THRESHOLD(1), .EMPTY_THRESHOLD(1), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .winc(f_winc), .wdata(f_wdata), .wfull(f_wfull),
        .almost_full(f_almost_full), .overflow_error(f_overflow), .rinc(f_rinc),
        .rdata(f_rdata), .rempty(f_rempty), .almost_empty(f_almost_empty),
        .underflow_error(f_underflow), .err_clr(f_err_clr), .count(f_count)
    );

    typedef struct {
        logic       winc;
        logic       rinc;
        logic       err_clr;
        logic [7:0] wdata;
        logic [4:0] exp_count;
        logic       exp_rempty;
        logic       exp_aempty;
        logic       exp_wfull;
        logic       exp_afull;
        logic       exp_ovf;
        logic       exp_unf;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic c, input logic [7:0] d);
        winc = w; rinc = r; err_clr = c; wdata = d;
    endtask

    function automatic vec_t mk(input logic w, input logic r, input logic c, input logic [7:0] d,
                                input int cnt, input logic ovf, input logic unf, input logic [7:0] rd);
        vec_t v;
        v.winc = w; v.rinc = r; v.err_clr = c; v.wdata = d;
        v.exp_count  = 5'(cnt);
        v.exp_rempty = (cnt == 0);
        v.exp_aempty = (cnt <= 1);
        v.exp_wfull  = (cnt == 16);
        v.exp_afull  = (cnt >= 15);
        v.exp_ovf = ovf; v.exp_unf = unf; v.exp_rdata = rd;
        return v;
    endfunction

    initial begin
        // Fill 0x01..0x10, overflow attempt, clear, drain, underflow, set-beats-clear, clear.
        for (int i = 1; i <= 16; i++) vecs.push_back(mk(1, 0, 0, 8'(i), i, 0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 0, 8'h11, 16, 1, 0, 8'h00));
        vecs.push_back(mk(0, 0, 1, 8'h00, 16, 0, 0, 8'h00));
        for (int j = 1; j <= 16; j++) vecs.push_back(mk(0, 1, 0, 8'h00, 16 - j, 0, 0, 8'(j)));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 8'h10));
        vecs.push_back(mk(0, 1, 1, 8'h00, 0, 0, 1, 8'h10));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h10));

        f_winc = 0; f_rinc = 0; f_err_clr = 0; f_wdata = 8'h00;
        rst = 1'b1;
        drive(1, 1, 0, 8'hEE);
        tick();
        tick();
        $display("reset: count=%0d rempty=%0b aempty=%0b wfull=%0b afull=%0b rdata=0x%02h", count, rempty, almost_empty, wfull, almost_full, rdata);
        chk("reset_count", 32'(count), 0);
        chk("reset_rempty", 32'(rempty), 1);
        chk("reset_aempty", 32'(almost_empty), 1);
        chk("reset_wfull", 32'(wfull), 0);
        chk("reset_afull", 32'(almost_full), 0);
        chk("reset_ovf", 32'(overflow_error), 0);
        chk("reset_unf", 32'(underflow_error), 0);
        chk("reset_rdata", 32'(rdata), 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].winc, vecs[k].rinc, vecs[k].err_clr, vecs[k].wdata);
            tick();
            $display("vec %0d: w=%0b r=%0b c=%0b d=0x%02h -> count=%0d rdata=0x%02h ovf=%0b unf=%0b",
                     k, vecs[k].winc, vecs[k].rinc, vecs[k].err_clr, vecs[k].wdata, count, rdata, overflow_error, underflow_error);
            chk($sformatf("vec%0d_count", k),  32'(count),           32'(vecs[k].exp_count));
            chk($sformatf("vec%0d_rempty", k), 32'(rempty),          32'(vecs[k].exp_rempty));
            chk($sformatf("vec%0d_aempty", k), 32'(almost_empty),    32'(vecs[k].exp_aempty));
            chk($sformatf("vec%0d_wfull", k),  32'(wfull),           32'(vecs[k].exp_wfull));
            chk($sformatf("vec%0d_afull", k),  32'(almost_full),     32'(vecs[k].exp_afull));
            chk($sformatf("vec%0d_ovf", k),    32'(overflow_error),  32'(vecs[k].exp_ovf));
            chk($sformatf("vec%0d_unf", k),    32'(underflow_error), 32'(vecs[k].exp_unf));
            chk($sformatf("vec%0d_rdata", k),  32'(rdata),           32'(vecs[k].exp_rdata));
        end

        // Preload 8, then 40 concurrent write+read cycles crossing several pointer wraps.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 8'(8'h40 + i));
            tick();
        end
        chk("preload_count", 32'(count), 8);
        for (int c = 0; c < 40; c++) begin
            drive(1, 1, 0, 8'(8'h48 + c));
            tick();
            $display("concurrent %0d: count=%0d rdata=0x%02h", c, count, rdata);
            chk($sformatf("wrap%0d_count", c), 32'(count), 8);
            chk($sformatf("wrap%0d_rdata", c), 32'(rdata), 32'(8'h40 + c));
        end

        // Top up to full, then write+read on full: read wins, overflow set.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 8'(8'h70 + i));
            tick();
        end
        chk("topup_wfull", 32'(wfull), 1);
        drive(1, 1, 0, 8'hFF);
        tick();
        $display("wr+rd on full: count=%0d rdata=0x%02h ovf=%0b", count, rdata, overflow_error);
        chk("fullwr_count", 32'(count), 15);
        chk("fullwr_rdata", 32'(rdata), 32'h68);
        chk("fullwr_ovf", 32'(overflow_error), 1);
        chk("fullwr_wfull", 32'(wfull), 0);
        chk("fullwr_afull", 32'(almost_full), 1);

        // Bring occupancy to 9, then reset for one cycle with a write pending.
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 8'h00);
            tick();
            chk($sformatf("pre_rst_rdata%0d", i), 32'(rdata), 32'(8'h69 + i));
        end
        chk("pre_rst_count", 32'(count), 9);
        rst = 1'b1;
        drive(1, 0, 0, 8'hBB);
        tick();
        rst = 1'b0;
        $display("mid reset: count=%0d rempty=%0b ovf=%0b unf=%0b", count, rempty, overflow_error, underflow_error);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_rempty", 32'(rempty), 1);
        chk("midrst_ovf", 32'(overflow_error), 0);
        chk("midrst_unf", 32'(underflow_error), 0);
        drive(1, 0, 0, 8'h33);
        tick();
        drive(0, 1, 0, 8'h00);
        tick();
        drive(0, 0, 0, 8'h00);
        $display("post reset read: rdata=0x%02h count=%0d", rdata, count);
        chk("postrst_rdata", 32'(rdata), 32'h33);
        chk("postrst_count", 32'(count), 0);

        // FWFT instance: first word appears with rempty falling, no rinc needed.
        f_winc = 1; f_wdata = 8'hA5;
        tick();
        $display("fwft write A5: rempty=%0b rdata=0x%02h", f_rempty, f_rdata);
        chk("fwft_rempty", 32'(f_rempty), 0);
        chk("fwft_first", 32'(f_rdata), 32'hA5);
        f_wdata = 8'h5A;
        tick();
        f_winc = 0;
        chk("fwft_hold", 32'(f_rdata), 32'hA5);
        chk("fwft_count2", 32'(f_count), 2);
        f_rinc = 1;
        tick();
        $display("fwft rinc: rdata=0x%02h count=%0d", f_rdata, f_count);
        chk("fwft_next", 32'(f_rdata), 32'h5A);
        chk("fwft_count1", 32'(f_count), 1);
        tick();
        f_rinc = 0;
        chk("fwft_empty", 32'(f_rempty), 1);
        chk("fwft_unf", 32'(f_underflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
